// File: rtl/line_mem_ctrl.sv
// Single-port initiator for a 512-bit-line SRAM serving a 32-bit byte-addressed requester.
// Optional write protection below PROT_LIMIT is enabled by defining LINE_MEM_CTRL_WPROT_EN.
module line_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PROT_LIMIT = 32'h1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [ADDR_WIDTH+5:0]   i_req_addr,
  input  logic [31:0]             i_req_wdata,
  input  logic [3:0]              i_req_be,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_we,
  output logic [511:0]            o_mem_wdata,
  input  logic [511:0]            i_mem_q
);

  localparam int unsigned LINE_W = 512;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WSEL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  logic [WSEL_W-1:0]     r_word, w_word_nxt;
  logic [WORD_W-1:0]     r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]       r_be, w_be_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [LINE_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic [WORD_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;

  logic                  w_accept;
  logic                  w_prot;
  logic [LINE_W-1:0]     w_merged;
  logic [WORD_W-1:0]     w_rd_word;
  logic                  w_unused;

  assign o_req_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_unused    = &{1'b0, i_req_addr[1:0]};

`ifdef LINE_MEM_CTRL_WPROT_EN
  assign w_prot = i_req_we && (32'(i_req_addr) < PROT_LIMIT);
`else
  logic w_unused_prot;
  assign w_unused_prot = (PROT_LIMIT == 32'd0);
  assign w_prot        = 1'b0;
`endif

  // Selected word of the line just read, and the line with enabled bytes replaced.
  assign w_rd_word = i_mem_q[{r_word, 5'b0} +: WORD_W];

  always_comb begin
    w_merged = i_mem_q;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (r_be[b]) begin
        w_merged[{r_word, 2'(b), 3'b0} +: 8] = r_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_word_nxt      = r_word;
    w_wdata_nxt     = r_wdata;
    w_be_nxt        = r_be;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_we_nxt    = r_mem_we;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_valid_nxt = r_rsp_valid;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_we_nxt    = i_req_we;
          w_word_nxt  = i_req_addr[5:2];
          w_wdata_nxt = i_req_wdata;
          w_be_nxt    = i_req_be;
          if (w_prot) begin
            // Rejected write: answer immediately, SRAM untouched.
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = '0;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_RESP;
          end else begin
            w_mem_addr_nxt = i_req_addr[ADDR_WIDTH+5:6];
            w_mem_we_nxt   = 1'b0;
            w_rsp_err_nxt  = 1'b0;
            w_state_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        if (r_we) begin
          w_mem_wdata_nxt = w_merged;
          w_mem_we_nxt    = 1'b1;
          w_state_nxt     = S_WRITE;
        end else begin
          w_rsp_rdata_nxt = w_rd_word;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end
      S_WRITE: begin
        w_mem_we_nxt    = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_word      <= w_word_nxt;
      r_wdata     <= w_wdata_nxt;
      r_be        <= w_be_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;

endmodule
